store_unit: RTL and testbench
=============================

STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of addr and mem_addr.
REQ-002 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid  input  1: store request present.
REQ-005 SHALL have port req_ready  output  1: unit accepts a request this cycle.
REQ-006 SHALL have port funct3  input  3: store width; 000 SB, 001 SH, 010 SW.
REQ-007 SHALL have port amo_data_store  input  1: AMO write-back; forces SW regardless of funct3.
REQ-008 SHALL have port addr  input  ADDR_WIDTH: byte address.
REQ-009 SHALL have port wdata  input  32: register data, right-aligned.
REQ-010 SHALL have port mem_valid  output  1: memory write request.
REQ-011 SHALL have port mem_ready  input  1: memory accepts the write.
REQ-012 SHALL have port mem_addr  output  ADDR_WIDTH: word-aligned address {addr[W-1:2],2'b00}.
REQ-013 SHALL have port mem_wdata  output  32: lane-placed write data.
REQ-014 SHALL have port mem_wstrb  output  4: byte-lane enables.
REQ-015 SHALL have port done  output  1: one-cycle pulse on write completion.
REQ-016 SHALL have port fault_misaligned  output  1: one-cycle pulse on misaligned store.
REQ-017 SHALL have port fault_illegal  output  1: one-cycle pulse on unsupported funct3.

Function
REQ-018 SHALL implement FSM states IDLE, MEM, FAULT; req_ready = 1 only in IDLE.
REQ-019 SHALL accept a request on req_valid && req_ready, latching the decoded op, mem_addr, mem_wdata and mem_wstrb.
REQ-020 SHALL decode: amo_data_store=1 -> SW; else 000 SB, 001 SH, 010 SW, any other funct3 -> illegal.
REQ-021 SHALL place data: SB -> wdata[7:0] replicated x4, wstrb = 4'b0001 << addr[1:0]; SH -> wdata[15:0] replicated x2, wstrb = addr[1] ? 4'b1100 : 4'b0011; SW -> wdata, wstrb = 4'b1111.
REQ-022 SHALL flag misaligned for SH with addr[0]=1 and SW with addr[1:0]!=0; illegal takes priority over misaligned.
REQ-023 On accepting a faulting request SHALL go to FAULT, pulse exactly one fault output for one cycle, never assert mem_valid, then return to IDLE.
REQ-024 On accepting a good request SHALL go to MEM with mem_valid=1 the next cycle (accept cycle N -> mem_valid at N+1).
REQ-025 SHALL hold mem_valid, mem_addr, mem_wdata, mem_wstrb stable while mem_valid=1 and mem_ready=0, indefinitely.
REQ-026 On mem_valid && mem_ready SHALL deassert mem_valid next cycle, pulse done that cycle, return to IDLE; minimum latency accept N -> done N+2.
REQ-027 SHALL ignore mem_ready outside MEM and ignore req_valid outside IDLE.
REQ-028 SHALL allow a new request to be accepted in the cycle done is high (back-to-back stores every 2 cycles minimum).

Reset
REQ-029 SHALL on rst force state IDLE, mem_valid=0, done=0, both fault outputs 0, mem_addr/mem_wdata/mem_wstrb=0, asynchronously.
REQ-030 SHALL abandon an in-flight write on rst mid-MEM with no done pulse; req_ready=1 in the first cycle after rst deasserts.

Structure
REQ-031 SHALL take store-op encodings (STORE_OP_SB/SH/SW, STORE_OP_WIDTH) from the shared riscv_defines header alongside the load-op encodings.
REQ-032 SHALL contain one combinational sub-module store_decoder (funct3, amo_data_store -> STOREop, illegal); lane placement and FSM stay in store_unit.

Verification
REQ-033 SB addr=0x1003 wdata=0xAABBCCDD, mem_ready tied 1 -> mem_addr 0x1000, wstrb 1000, mem_wdata 0xDDDDDDDD, done 2 cycles after accept.
REQ-034 SH addr=0x2002 wdata=0x00001234, mem_ready low 5 cycles -> outputs stable 5 cycles, wstrb 1100, mem_wdata 0x12341234, single done.
REQ-035 SW addr=0x3001 -> fault_misaligned one pulse, mem_valid never high, req_ready back next cycle; funct3=011 addr=0x3001 -> fault_illegal only.
REQ-036 amo_data_store=1 funct3=000 addr=0x4000 wdata=0x11223344 -> wstrb 1111, mem_wdata 0x11223344.
REQ-037 rst asserted during MEM with mem_ready=0 -> mem_valid 0 immediately, no done; next SW at 0x5000 completes normally.
REQ-038 Back-to-back SW requests with req_valid held high and mem_ready=1 -> one done every 2 cycles, no request dropped or duplicated.

Source files
------------

// File: rtl/store_unit_pkg.sv
// Shared RISC-V defines: load/store op encodings and store-unit FSM state type.
// Imported by store_decoder and store_unit.
package store_unit_pkg;

    localparam int LOAD_OP_WIDTH  = 3;
    localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LB  = 3'd0;
    localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LH  = 3'd1;
    localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LW  = 3'd2;
    localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LBU = 3'd3;
    localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LHU = 3'd4;

    localparam int STORE_OP_WIDTH = 2;
    localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SB = 2'd0;
    localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SH = 2'd1;
    localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SW = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MEM   = 2'd1,
        ST_FAULT = 2'd2
    } store_state_t;

endpackage

// File: rtl/store_unit_decoder.sv
// Combinational store decode: funct3/AMO flag to store op plus illegal flag.
// AMO write-back always behaves as a full-word store.
module store_decoder
    import store_unit_pkg::*;
(
    input  logic [2:0]                funct3,
    input  logic                      amo_data_store,
    output logic [STORE_OP_WIDTH-1:0] store_op,
    output logic                      illegal
);

    always_comb begin
        store_op = STORE_OP_SW;
        illegal  = 1'b0;
        if (!amo_data_store) begin
            case (funct3)
                3'b000:  store_op = STORE_OP_SB;
                3'b001:  store_op = STORE_OP_SH;
                3'b010:  store_op = STORE_OP_SW;
                default: illegal  = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/store_unit.sv
// Store unit: decodes a store, places data on byte lanes and runs a
// valid/ready write to memory, or reports a one-cycle fault.
//
// state    | meaning
// ST_IDLE  | ready for a new request
// ST_MEM   | mem_valid high, waiting for mem_ready
// ST_FAULT | one cycle pulsing the latched fault output
module store_unit
    import store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            funct3,
    input  logic                  amo_data_store,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    output logic                  done,
    output logic                  fault_misaligned,
    output logic                  fault_illegal
);

    store_state_t state, state_next;

    logic [STORE_OP_WIDTH-1:0] store_op;
    logic                      illegal;
    logic                      misaligned;
    logic                      accept;
    logic [31:0]               lane_data;
    logic [3:0]                lane_strb;

    store_decoder u_decoder (
        .funct3         (funct3),
        .amo_data_store (amo_data_store),
        .store_op       (store_op),
        .illegal        (illegal)
    );

    assign req_ready = (state == ST_IDLE);
    assign mem_valid = (state == ST_MEM);
    assign accept    = req_valid && req_ready;

    // Illegal wins: misaligned is only meaningful for a decodable op.
    assign misaligned = !illegal &&
                        (((store_op == STORE_OP_SH) && addr[0]) ||
                         ((store_op == STORE_OP_SW) && (addr[1:0] != 2'b00)));

    always_comb begin
        lane_data = wdata;
        lane_strb = 4'b1111;
        case (store_op)
            STORE_OP_SB: begin
                lane_data = {4{wdata[7:0]}};
                lane_strb = 4'b0001 << addr[1:0];
            end
            STORE_OP_SH: begin
                lane_data = {2{wdata[15:0]}};
                lane_strb = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                lane_data = wdata;
                lane_strb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (illegal || misaligned) ? ST_FAULT : ST_MEM;
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_next = ST_IDLE;
                end
            end
            ST_FAULT: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            done             <= 1'b0;
            fault_misaligned <= 1'b0;
            fault_illegal    <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
            mem_wstrb        <= '0;
        end else begin
            state            <= state_next;
            done             <= (state == ST_MEM) && mem_ready;
            fault_illegal    <= accept && illegal;
            fault_misaligned <= accept && misaligned;
            if (accept) begin
                mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                mem_wdata <= lane_data;
                mem_wstrb <= lane_strb;
            end
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// Directed self-checking bench for store_unit: lane placement, stalls,
// faults, AMO override, reset abort and back-to-back throughput.
module tb_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  funct3 = 3'b000;
    logic        amo_data_store = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        done;
    logic        fault_misaligned;
    logic        fault_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    store_unit #(.ADDR_WIDTH(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .funct3           (funct3),
        .amo_data_store   (amo_data_store),
        .addr             (addr),
        .wdata            (wdata),
        .mem_valid        (mem_valid),
        .mem_ready        (mem_ready),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_wstrb        (mem_wstrb),
        .done             (done),
        .fault_misaligned (fault_misaligned),
        .fault_illegal    (fault_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [2:0] f3, input logic amo,
                           input logic [31:0] a, input logic [31:0] d);
        req_valid      = 1'b1;
        funct3         = f3;
        amo_data_store = amo;
        addr           = a;
        wdata          = d;
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_faults", {30'd0, fault_misaligned, fault_illegal}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // SB at byte 3, memory always ready
        mem_ready = 1'b1;
        request(3'b000, 1'b0, 32'h0000_1003, 32'hAABB_CCDD);
        check("sb_req_ready", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        check("sb_mem_valid", {31'd0, mem_valid}, 32'd1);
        check("sb_mem_addr", mem_addr, 32'h0000_1000);
        check("sb_mem_wstrb", {28'd0, mem_wstrb}, 32'b1000);
        check("sb_mem_wdata", mem_wdata, 32'hDDDD_DDDD);
        check("sb_done_early", {31'd0, done}, 32'd0);
        check("sb_busy", {31'd0, req_ready}, 32'd0);
        tick();
        check("sb_done", {31'd0, done}, 32'd1);
        check("sb_mem_valid_drop", {31'd0, mem_valid}, 32'd0);
        tick();
        check("sb_done_single", {31'd0, done}, 32'd0);

        // SH upper half with a 5-cycle memory stall
        mem_ready = 1'b0;
        request(3'b001, 1'b0, 32'h0000_2002, 32'h0000_1234);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("sh_stall_valid", {31'd0, mem_valid}, 32'd1);
            check("sh_stall_addr", mem_addr, 32'h0000_2000);
            check("sh_stall_wstrb", {28'd0, mem_wstrb}, 32'b1100);
            check("sh_stall_wdata", mem_wdata, 32'h1234_1234);
            check("sh_stall_done", {31'd0, done}, 32'd0);
            tick();
        end
        mem_ready = 1'b1;
        tick();
        check("sh_done", {31'd0, done}, 32'd1);
        check("sh_valid_drop", {31'd0, mem_valid}, 32'd0);
        tick();
        check("sh_done_single", {31'd0, done}, 32'd0);

        // SW misaligned
        request(3'b010, 1'b0, 32'h0000_3001, 32'h5555_AAAA);
        tick();
        req_valid = 1'b0;
        check("sw_mis_fault", {31'd0, fault_misaligned}, 32'd1);
        check("sw_mis_no_illegal", {31'd0, fault_illegal}, 32'd0);
        check("sw_mis_no_mem", {31'd0, mem_valid}, 32'd0);
        check("sw_mis_busy", {31'd0, req_ready}, 32'd0);
        tick();
        check("sw_mis_pulse_end", {31'd0, fault_misaligned}, 32'd0);
        check("sw_mis_ready_back", {31'd0, req_ready}, 32'd1);
        check("sw_mis_no_mem2", {31'd0, mem_valid}, 32'd0);
        check("sw_mis_no_done", {31'd0, done}, 32'd0);

        // Illegal funct3 on a misaligned address: illegal wins
        request(3'b011, 1'b0, 32'h0000_3001, 32'h0);
        tick();
        req_valid = 1'b0;
        check("ill_fault", {31'd0, fault_illegal}, 32'd1);
        check("ill_no_mis", {31'd0, fault_misaligned}, 32'd0);
        check("ill_no_mem", {31'd0, mem_valid}, 32'd0);
        tick();
        check("ill_pulse_end", {31'd0, fault_illegal}, 32'd0);
        check("ill_ready_back", {31'd0, req_ready}, 32'd1);

        // SH with odd address is misaligned
        request(3'b001, 1'b0, 32'h0000_2001, 32'h0);
        tick();
        req_valid = 1'b0;
        check("sh_mis_fault", {30'd0, fault_misaligned, fault_illegal}, 32'b10);
        check("sh_mis_no_mem", {31'd0, mem_valid}, 32'd0);
        tick();

        // SB at byte 1 and SH lower half lane placement
        request(3'b000, 1'b0, 32'h0000_2101, 32'h0000_00A5);
        tick();
        req_valid = 1'b0;
        check("sb1_wstrb", {28'd0, mem_wstrb}, 32'b0010);
        check("sb1_wdata", mem_wdata, 32'hA5A5_A5A5);
        tick();
        request(3'b001, 1'b0, 32'h0000_2104, 32'hFFFF_BEEF);
        tick();
        req_valid = 1'b0;
        check("sh0_wstrb", {28'd0, mem_wstrb}, 32'b0011);
        check("sh0_wdata", mem_wdata, 32'hBEEF_BEEF);
        check("sh0_addr", mem_addr, 32'h0000_2104);
        tick();

        // AMO write-back overrides funct3
        request(3'b000, 1'b1, 32'h0000_4000, 32'h1122_3344);
        tick();
        req_valid = 1'b0;
        amo_data_store = 1'b0;
        check("amo_wstrb", {28'd0, mem_wstrb}, 32'b1111);
        check("amo_wdata", mem_wdata, 32'h1122_3344);
        check("amo_addr", mem_addr, 32'h0000_4000);
        tick();
        check("amo_done", {31'd0, done}, 32'd1);
        tick();

        // Reset mid-write abandons it
        mem_ready = 1'b0;
        request(3'b010, 1'b0, 32'h0000_6000, 32'hDEAD_BEEF);
        tick();
        req_valid = 1'b0;
        check("abort_in_mem", {31'd0, mem_valid}, 32'd1);
        tick();
        rst = 1'b1;
        #1;
        check("abort_valid_async", {31'd0, mem_valid}, 32'd0);
        check("abort_wstrb_async", {28'd0, mem_wstrb}, 32'd0);
        mem_ready = 1'b1;
        tick();
        check("abort_no_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        request(3'b010, 1'b0, 32'h0000_5000, 32'hCAFE_F00D);
        tick();
        req_valid = 1'b0;
        check("post_rst_valid", {31'd0, mem_valid}, 32'd1);
        check("post_rst_addr", mem_addr, 32'h0000_5000);
        check("post_rst_wdata", mem_wdata, 32'hCAFE_F00D);
        check("post_rst_wstrb", {28'd0, mem_wstrb}, 32'b1111);
        tick();
        check("post_rst_done", {31'd0, done}, 32'd1);
        tick();

        // Back-to-back SW, req_valid held high: one done every 2 cycles
        request(3'b010, 1'b0, 32'h0000_7000, 32'h0000_0100);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("b2b_valid", {31'd0, mem_valid}, 32'd1);
            check("b2b_wdata", mem_wdata, 32'h0000_0100 + 32'(k));
            check("b2b_addr", mem_addr, 32'h0000_7000 + 32'(4 * k));
            check("b2b_no_done", {31'd0, done}, 32'd0);
            wdata = 32'h0000_0100 + 32'(k + 1);
            addr  = 32'h0000_7000 + 32'(4 * (k + 1));
            tick();
            check("b2b_done", {31'd0, done}, 32'd1);
            check("b2b_ready", {31'd0, req_ready}, 32'd1);
            if (k == 3) req_valid = 1'b0;
        end
        tick();
        check("b2b_no_extra", {31'd0, mem_valid}, 32'd0);
        check("b2b_done_end", {31'd0, done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
